// File: rtl/lut_cfg_ctrl_pkg.sv
// Shared types and helpers for the key->data lookup table controller.
package lut_cfg_ctrl_pkg;

  localparam int DEF_KEY_NUM  = 4;
  localparam int DEF_KEY_LEN  = 2;
  localparam int DEF_DATA_LEN = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lut_state_e;

  // Index width with room for at least one out-of-range code, so that a
  // write to an index past the last entry can be expressed and flagged.
  function automatic int idxWidth(input int keyNum);
    return $clog2(keyNum + 1);
  endfunction

endpackage

// File: rtl/lut_cfg_ctrl_match.sv
// Combinational key comparator: flags every valid entry whose key matches and
// ORs together the data of all matching entries.
module lut_cfg_ctrl_match
  import lut_cfg_ctrl_pkg::*;
#(
  parameter int KEY_NUM  = DEF_KEY_NUM,
  parameter int KEY_LEN  = DEF_KEY_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic [KEY_NUM-1:0]                i_valid,
  input  logic [KEY_NUM-1:0][KEY_LEN-1:0]   i_keys,
  input  logic [KEY_NUM-1:0][DATA_LEN-1:0]  i_data,
  input  logic [KEY_LEN-1:0]                i_key,
  output logic                              o_hit,
  output logic [DATA_LEN-1:0]               o_data
);

  // Scan all entries; duplicate valid keys merge their data bitwise.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (i_valid[i] && (i_keys[i] == i_key)) begin
        o_hit  = 1'b1;
        o_data = o_data | i_data[i];
      end
    end
  end

endmodule

// File: rtl/lut_cfg_ctrl.sv
// Programmable key->data lookup table. Arbitrates config writes, a full-table
// invalidate sweep and lookups; results leave through one registered,
// backpressured output stage.
module lut_cfg_ctrl
  import lut_cfg_ctrl_pkg::*;
#(
  parameter int KEY_NUM     = DEF_KEY_NUM,
  parameter int KEY_LEN     = DEF_KEY_LEN,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = idxWidth(KEY_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [IDX_W-1:0]    i_cfg_idx,
  input  logic [KEY_LEN-1:0]  i_cfg_key,
  input  logic [DATA_LEN-1:0] i_cfg_data,
  output logic                o_cfg_err,
  input  logic                i_clr_req,
  output logic                o_busy,
  input  logic [DATA_LEN-1:0] i_default_data,
  input  logic                i_lk_valid,
  output logic                o_lk_ready,
  input  logic [KEY_LEN-1:0]  i_lk_key,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [DATA_LEN-1:0] o_res_data,
  output logic                o_res_hit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_NUM - 1);
  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(KEY_NUM);

  lut_state_e                        r_state;
  lut_state_e                        w_nextState;
  logic [IDX_W-1:0]                  r_sweepIdx;
  logic [KEY_NUM-1:0]                r_valid;
  logic [KEY_NUM-1:0][KEY_LEN-1:0]   r_keys;
  logic [KEY_NUM-1:0][DATA_LEN-1:0]  r_data;
  logic                              r_resValid;
  logic                              r_resHit;
  logic [DATA_LEN-1:0]               r_resData;
  logic                              r_cfgErr;

  logic                              w_busy;
  logic                              w_cfgReady;
  logic                              w_lkReady;
  logic                              w_cfgAccept;
  logic                              w_lkAccept;
  logic                              w_idxInRange;
  logic                              w_matchHit;
  logic [DATA_LEN-1:0]               w_matchData;
  logic [DATA_LEN-1:0]               w_missData;

  assign w_cfgAccept  = i_cfg_valid && w_cfgReady;
  assign w_lkAccept   = i_lk_valid && w_lkReady;
  assign w_idxInRange = (i_cfg_idx < NUM_IDX);
  assign w_missData   = (HAS_DEFAULT != 0) ? i_default_data : '0;

  // The comparator always sees the registered table, so a write in the same
  // cycle as a lookup only becomes visible to the following lookup.
  lut_cfg_ctrl_match #(
    .KEY_NUM  (KEY_NUM),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_match (
    .i_valid (r_valid),
    .i_keys  (r_keys),
    .i_data  (r_data),
    .i_key   (i_lk_key),
    .o_hit   (w_matchHit),
    .o_data  (w_matchData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Next state: a clear request in IDLE starts the sweep, which ends on the last entry.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_clr_req) w_nextState = ST_CLEAR;
      ST_CLEAR: if (r_sweepIdx == LAST_IDX) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs: a pending clear request outranks both writes and lookups.
  always_comb begin
    w_busy     = (r_state == ST_CLEAR);
    w_cfgReady = (r_state == ST_IDLE) && !i_clr_req;
    w_lkReady  = w_cfgReady && (!r_resValid || i_res_ready);
  end

  // Sweep counter walks entries 0..KEY_NUM-1, one per CLEAR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_sweepIdx <= '0;
    else if (r_state != ST_CLEAR)  r_sweepIdx <= '0;
    else if (r_sweepIdx == LAST_IDX) r_sweepIdx <= '0;
    else                           r_sweepIdx <= r_sweepIdx + IDX_W'(1);
  end

  // Table storage: the sweep invalidates entries, accepted in-range writes fill them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_keys  <= '0;
      r_data  <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if ((r_state == ST_CLEAR) && (r_sweepIdx == IDX_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (w_cfgAccept && (i_cfg_idx == IDX_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_keys[i]  <= i_cfg_key;
          r_data[i]  <= i_cfg_data;
        end
      end
    end
  end

  // Out-of-range writes are still accepted but raise a one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfgErr <= 1'b0;
    else        r_cfgErr <= w_cfgAccept && !w_idxInRange;
  end

  // Result register: loads on an accepted lookup, empties when consumed, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resValid <= 1'b0;
      r_resHit   <= 1'b0;
      r_resData  <= '0;
    end else if (w_lkAccept) begin
      r_resValid <= 1'b1;
      r_resHit   <= w_matchHit;
      r_resData  <= w_matchHit ? w_matchData : w_missData;
    end else if (i_res_ready) begin
      r_resValid <= 1'b0;
    end
  end

  assign o_cfg_ready = w_cfgReady;
  assign o_lk_ready  = w_lkReady;
  assign o_busy      = w_busy;
  assign o_cfg_err   = r_cfgErr;
  assign o_res_valid = r_resValid;
  assign o_res_hit   = r_resHit;
  assign o_res_data  = r_resData;

endmodule
